// File: rtl/gpio_seq_checker.sv
// Self-checking GPIO monitor: glitch-filters gpio_in and matches each settled change
// against a preloaded expected-value FIFO, reporting pass, mismatch or timeout.
module gpio_seq_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           gpio_in,
  input  logic                       exp_wr,
  input  logic [WIDTH-1:0]           exp_data,
  output logic                       exp_full,
  input  logic                       start,
  input  logic                       clear,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail_mismatch,
  output logic                       fail_timeout,
  output logic [$clog2(DEPTH+1)-1:0] match_count,
  output logic [WIDTH-1:0]           last_value,
  output logic [31:0]                cycle_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  last_q, last_d, filt_val_q, filt_val_d;
  logic [CW-1:0]     match_q, match_d;
  logic [31:0]       cyc_q, cyc_d, cyc_inc;
  logic [SW-1:0]     filt_cnt_q, filt_cnt_d, stable_n;
  logic              fail_mm_q, fail_mm_d, fail_to_q, fail_to_d;
  logic              push, pop, empty, full, diff, accept, last_pop;
  logic [WIDTH-1:0]  head;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign last_pop = ((rd_ptr_q + PW'(1)) == wr_ptr_q);
  assign cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

  // Count of consecutive identical non-last values, including this cycle.
  assign diff     = (gpio_in != last_q);
  assign stable_n = (filt_cnt_q != '0 && gpio_in == filt_val_q) ? filt_cnt_q + SW'(1) : SW'(1);
  assign accept   = (state_q == StRun) && diff && (stable_n == SW'(SETTLE));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_d     = last_q;
    filt_val_d = filt_val_q;
    filt_cnt_d = filt_cnt_q;
    match_d    = match_q;
    cyc_d      = cyc_q;
    fail_mm_d  = fail_mm_q;
    fail_to_d  = fail_to_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (clear) begin
      state_d    = StIdle;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      last_d     = '0;
      filt_cnt_d = '0;
      match_d    = '0;
      cyc_d      = '0;
      fail_mm_d  = 1'b0;
      fail_to_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          push = exp_wr && !full;
          if (start && !empty) begin
            state_d    = StRun;
            last_d     = gpio_in;
            filt_cnt_d = '0;
            match_d    = '0;
            cyc_d      = '0;
          end
        end
        StRun: begin
          cyc_d = cyc_inc;
          if (!diff || accept) begin
            filt_cnt_d = '0;
          end else begin
            filt_cnt_d = stable_n;
            filt_val_d = gpio_in;
          end
          if (accept) last_d = gpio_in;

          if (accept && gpio_in == head) begin
            pop     = 1'b1;
            match_d = match_q + CW'(1);
          end

          // Completion beats mismatch beats timeout.
          if (accept && gpio_in == head && last_pop) begin
            state_d = StPass;
          end else if (accept && gpio_in != head) begin
            state_d   = StFail;
            fail_mm_d = 1'b1;
          end else if (cyc_inc >= 32'(TIMEOUT)) begin
            state_d   = StFail;
            fail_to_d = 1'b1;
          end
        end
        default: ;
      endcase
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_q     <= '0;
      filt_val_q <= '0;
      filt_cnt_q <= '0;
      match_q    <= '0;
      cyc_q      <= '0;
      fail_mm_q  <= 1'b0;
      fail_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_q     <= last_d;
      filt_val_q <= filt_val_d;
      filt_cnt_q <= filt_cnt_d;
      match_q    <= match_d;
      cyc_q      <= cyc_d;
      fail_mm_q  <= fail_mm_d;
      fail_to_q  <= fail_to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= exp_data;
  end

  assign exp_full      = full;
  assign busy          = (state_q == StRun);
  assign done          = (state_q == StPass) || (state_q == StFail);
  assign pass          = (state_q == StPass);
  assign fail_mismatch = fail_mm_q;
  assign fail_timeout  = fail_to_q;
  assign match_count   = match_q;
  assign last_value    = last_q;
  assign cycle_count   = cyc_q;

endmodule

// File: tb/tb_gpio_seq_checker.sv
// Scoreboard bench for gpio_seq_checker: expected values are queued as they are loaded
// and popped as the DUT reports each accepted match.
module tb_gpio_seq_checker;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] gpio_in = '0;
  logic             exp_wr = 1'b0;
  logic [WIDTH-1:0] exp_data = '0;
  logic             exp_full;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic             busy, done, pass, fail_mismatch, fail_timeout;
  logic [CW-1:0]    match_count;
  logic [WIDTH-1:0] last_value;
  logic [31:0]      cycle_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb_q [$];
  logic [CW-1:0]    prev_mc = '0;
  logic [31:0]      held_cc;

  gpio_seq_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .gpio_in(gpio_in), .exp_wr(exp_wr), .exp_data(exp_data),
    .exp_full(exp_full), .start(start), .clear(clear), .busy(busy), .done(done),
    .pass(pass), .fail_mismatch(fail_mismatch), .fail_timeout(fail_timeout),
    .match_count(match_count), .last_value(last_value), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each new match must correspond to the oldest outstanding expected value.
  always @(negedge clk) begin
    if (!reset && match_count != prev_mc && match_count != '0) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(match_count), 32'(prev_mc));
      end else begin
        check("sb_match_step", 32'(match_count), 32'(prev_mc) + 1);
        check("sb_last_value", 32'(last_value), 32'(sb_q.pop_front()));
      end
    end
    prev_mc = match_count;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    exp_wr   = 1'b1;
    exp_data = v;
    if (sb_q.size() < DEPTH) sb_q.push_back(v);
    step();
    exp_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    sb_q.delete();
  endtask

  task automatic drive(input logic [WIDTH-1:0] v, input int n);
    gpio_in = v;
    repeat (n) step();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    check("wait_done", 32'(done), 1);
  endtask

  initial begin
    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_fail", 32'({fail_mismatch, fail_timeout}), 0);
    check("rst_counts", 32'(match_count) | 32'(last_value) | cycle_count, 0);
    reset = 1'b0;
    step();
    check("rst_full", 32'(exp_full), 0);

    // T1: four-step walking sequence
    load(8'h01); load(8'h02); load(8'h04); load(8'h08);
    check("t1_full", 32'(exp_full), 1);
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    drive(8'h01, 6); drive(8'h02, 6); drive(8'h04, 6); drive(8'h08, 6);
    wait_done(10);
    check("t1_pass", 32'(pass), 1);
    check("t1_match", 32'(match_count), 4);
    check("t1_last", 32'(last_value), 32'h08);
    check("t1_flags", 32'({fail_mismatch, fail_timeout}), 0);
    check("t1_empty", 32'(exp_full), 0);
    held_cc = cycle_count;
    pulse_start();
    drive(8'h55, 5);
    check("t1_sticky_pass", 32'(pass), 1);
    check("t1_hold_cc", cycle_count, held_cc);
    check("t1_hold_last", 32'(last_value), 32'h08);
    pulse_clear();
    check("clr_done", 32'(done), 0);

    // T2: second value mismatches
    gpio_in = 8'h00;
    load(8'h01); load(8'h03);
    pulse_start();
    drive(8'h01, 6); drive(8'h07, 6);
    wait_done(10);
    check("t2_mismatch", 32'(fail_mismatch), 1);
    check("t2_timeout", 32'(fail_timeout), 0);
    check("t2_pass", 32'(pass), 0);
    check("t2_match", 32'(match_count), 1);
    check("t2_last", 32'(last_value), 32'h07);
    pulse_clear();

    // T3: single-cycle glitch must not be accepted
    gpio_in = 8'h00;
    load(8'h01);
    pulse_start();
    drive(8'hFF, 1);
    check("t3_no_glitch", 32'(last_value), 0);
    drive(8'h00, 2);
    check("t3_return", 32'(last_value), 0);
    drive(8'hFF, 1);
    drive(8'h01, 6);
    wait_done(10);
    check("t3_pass", 32'(pass), 1);
    check("t3_last", 32'(last_value), 32'h01);
    check("t3_match", 32'(match_count), 1);
    pulse_clear();

    // T4: no change ever arrives
    gpio_in = 8'h00;
    load(8'h01);
    pulse_start();
    wait_done(TIMEOUT + 20);
    check("t4_timeout", 32'(fail_timeout), 1);
    check("t4_mismatch", 32'(fail_mismatch), 0);
    check("t4_cycles", cycle_count, TIMEOUT);
    check("t4_match", 32'(match_count), 0);
    pulse_clear();

    // T5: overfill drops extras; only DEPTH values form the sequence
    gpio_in = 8'h00;
    for (int i = 0; i < DEPTH + 2; i++) load(8'h10 + 8'(i));
    check("t5_full", 32'(exp_full), 1);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) drive(8'h10 + 8'(i), 6);
    wait_done(10);
    check("t5_pass_depth", 32'(pass), 1);
    check("t5_match_depth", 32'(match_count), DEPTH);
    load(8'h77);
    check("t5_wr_ignored", 32'(exp_full), 0);
    pulse_clear();
    check("t5_clr_full", 32'(exp_full), 0);
    gpio_in = 8'h00;
    load(8'h21); load(8'h22);
    pulse_start();
    drive(8'h21, 6); drive(8'h22, 6);
    wait_done(10);
    check("t5_pass2", 32'(pass), 1);
    check("t5_match2", 32'(match_count), 2);
    pulse_clear();

    // T6: asynchronous reset mid-run
    gpio_in = 8'h00;
    load(8'h01); load(8'h02);
    pulse_start();
    drive(8'h01, 6);
    check("t6_pre_match", 32'(match_count), 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_state", 32'({busy, done, pass, fail_mismatch, fail_timeout}), 0);
    check("t6_rst_counts", 32'(match_count) | 32'(last_value) | cycle_count, 0);
    sb_q.delete();
    step();
    reset = 1'b0;
    step();
    pulse_start();
    check("t6_start_ignored", 32'(busy), 0);
    check("t6_fifo_empty", 32'(exp_full), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
